truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
//
// PURPOSE
//   Sequencer for a combinational Boolean function block (fxy-style, 3 inputs,
//   1 output). On start, the scanner:
//   - drives every input vector 0..2^N_IN-1 in ascending order onto the
//     function's inputs;
//   - waits a settle time;
//   - samples the function's output and assembles the full truth table plus a
//     count of minterms.
//   It sits between the test/display logic and the function under evaluation,
//   replacing hand-written stimulus sequences.
//
// PARAMETERS
//   N_IN    3   number of function inputs; vec width; table has 2^N_IN rows
//   SETTLE  1   cycles vec is held before sampling (legal range 1..15)
//
// PORTS
//   clk        in   1           rising-edge clock
//   rst_n      in   1           synchronous reset, active low
//   start      in   1           request a full scan; accepted only in IDLE
//   abort      in   1           terminate a scan in progress
//   s_in       in   1           output s of the function under evaluation
//   vec        out  N_IN        drives {x,y,z}; MSB = x, LSB = z
//   busy       out  1           high from accepted start until done/abort
//   done       out  1           1-cycle pulse: scan complete, table valid
//   aborted    out  1           1-cycle pulse: scan abandoned
//   row_valid  out  1           1-cycle pulse per row captured
//   row_idx    out  N_IN        row just captured (valid with row_valid)
//   row_bit    out  1           value captured for row_idx
//   tbl        out  2^N_IN      tbl[i] = s sampled with vec==i
//   ones_cnt   out  N_IN+1      number of 1s in tbl
//
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (rst_n==0 at a clk edge) sets:
//     - state = IDLE, vec = 0, settle counter = 0;
//     - busy, done, aborted, row_valid, row_idx, row_bit = 0;
//     - tbl = 0, ones_cnt = 0.
//     Reset wins over every other input, including mid-scan.
//   - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   - IDLE:
//     - start=1 -> SETTLE; vec=0, tbl=0, ones_cnt=0, busy=1,
//       settle counter = SETTLE-1.
//     - abort is ignored in IDLE.
//   - SETTLE:
//     - vec is held stable.
//     - Counter != 0: decrement, stay in SETTLE.
//     - Counter == 0: go to SAMPLE.
//   - SAMPLE (exactly 1 cycle; the edge leaving SAMPLE performs all of):
//     - tbl[vec] <= s_in; ones_cnt += s_in;
//     - row_valid=1, row_idx=vec, row_bit=s_in (visible in the next cycle);
//     - if vec == 2^N_IN-1: go to DONE, vec holds its value;
//     - else: vec <= vec+1, counter reloaded to SETTLE-1, go to SETTLE.
//   - Row timing: each row costs SETTLE+1 cycles.
//   - DONE (1 cycle):
//     - done=1 and busy=0 in this cycle; next state IDLE.
//     - start during DONE is ignored; it must be re-asserted in IDLE.
//   - Latency: done is high exactly 1 + 2^N_IN*(SETTLE+1) cycles after the
//     edge that accepted start (17 cycles with the defaults).
//   - abort in SETTLE or SAMPLE:
//     - next state IDLE; busy=0, aborted=1 for 1 cycle, done stays 0.
//     - abort has priority over capture in the same SAMPLE cycle: that row is
//       not written and row_valid is not pulsed.
//     - tbl and ones_cnt keep the partial result; vec holds its last value.
//   - start while busy is ignored (no restart).
//   - tbl and ones_cnt hold their value after done until the next accepted
//     start.
//   - ones_cnt never wraps: its maximum is 2^N_IN, which fits in N_IN+1 bits.
//
// TESTING
//   1. s_in = x & ~y (fed from vec), defaults, 1-cycle start pulse:
//      - tbl == 8'b0011_0000, ones_cnt == 2;
//      - done pulses 17 cycles after the start edge;
//      - 8 row_valid pulses with row_idx 0..7.
//   2. s_in tied 1, SETTLE=3 -> tbl == 8'hFF, ones_cnt == 8, done after
//      33 cycles.
//   3. abort asserted in the SAMPLE cycle of row 3, with s_in = x & ~y:
//      - aborted pulses, done never asserts;
//      - tbl == 0, ones_cnt == 0, no row_valid for row 3.
//   4. start held high for the whole scan -> exactly one scan; done pulses
//      once; a second scan starts only on the IDLE cycle after DONE.
//   5. rst_n=0 mid-scan at row 5 -> next cycle all outputs 0, state IDLE;
//      a fresh start then gives a full correct table.
//   6. abort and start both high in IDLE -> scan starts normally; the abort
//      is ignored.

Source files
------------

// File: rtl/truth_table_scanner_if.sv
// Bus between the truth-table scanner and its controller/function block:
// scan control, the function's input vector and output bit, and the result.
interface truth_table_scanner_if #(
    parameter int N_IN = 3
);
    logic                    start;
    logic                    abort;
    logic                    s_in;
    logic [N_IN-1:0]         vec;
    logic                    busy;
    logic                    done;
    logic                    aborted;
    logic                    row_valid;
    logic [N_IN-1:0]         row_idx;
    logic                    row_bit;
    logic [(1 << N_IN)-1:0]  tbl;
    logic [N_IN:0]           ones_cnt;

    modport master (
        output start, abort, s_in,
        input  vec, busy, done, aborted, row_valid, row_idx, row_bit, tbl, ones_cnt
    );

    modport slave (
        input  start, abort, s_in,
        output vec, busy, done, aborted, row_valid, row_idx, row_bit, tbl, ones_cnt
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks every input vector of an N_IN-input Boolean function, waits SETTLE
// cycles per vector, captures the output into a truth table and counts minterms.
module truth_table_scanner #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_scanner_if.slave bus
);
    localparam int              ROWS       = 1 << N_IN;
    localparam logic [N_IN-1:0] VEC_LAST   = N_IN'(ROWS - 1);
    localparam logic [N_IN-1:0] VEC_ONE    = N_IN'(1);
    localparam logic [3:0]      CNT_RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              row_valid_q, row_valid_d;
    logic [N_IN-1:0]   row_idx_q, row_idx_d;
    logic              row_bit_q, row_bit_d;
    logic [ROWS-1:0]   tbl_q, tbl_d;
    logic [N_IN:0]     ones_q, ones_d;

    // Next-state and output logic; pulses default low, everything else holds.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        row_valid_d = 1'b0;
        row_idx_d   = row_idx_q;
        row_bit_d   = row_bit_q;
        tbl_d       = tbl_q;
        ones_d      = ones_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SETTLE;
                    vec_d   = {N_IN{1'b0}};
                    tbl_d   = {ROWS{1'b0}};
                    ones_d  = {(N_IN+1){1'b0}};
                    busy_d  = 1'b1;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // Abort wins over capture: the current row is left unwritten.
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else begin
                    tbl_d[vec_q] = bus.s_in;
                    ones_d       = ones_q + {{N_IN{1'b0}}, bus.s_in};
                    row_valid_d  = 1'b1;
                    row_idx_d    = vec_q;
                    row_bit_d    = bus.s_in;
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + VEC_ONE;
                        cnt_d   = CNT_RELOAD;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= {N_IN{1'b0}};
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            row_valid_q <= 1'b0;
            row_idx_q   <= {N_IN{1'b0}};
            row_bit_q   <= 1'b0;
            tbl_q       <= {ROWS{1'b0}};
            ones_q      <= {(N_IN+1){1'b0}};
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            row_valid_q <= row_valid_d;
            row_idx_q   <= row_idx_d;
            row_bit_q   <= row_bit_d;
            tbl_q       <= tbl_d;
            ones_q      <= ones_d;
        end
    end

    assign bus.vec       = vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.row_valid = row_valid_q;
    assign bus.row_idx   = row_idx_q;
    assign bus.row_bit   = row_bit_q;
    assign bus.tbl       = tbl_q;
    assign bus.ones_cnt  = ones_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3) share
// stimulus and are checked every cycle against an elapsed-cycle timing model.
`timescale 1ns/1ps
module tb_truth_table_scanner;
    localparam int N_IN = 3;
    localparam int ROWS = 8;
    localparam int SET0 = 1;
    localparam int SET1 = 3;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [7:0] fn_tbl;
    int         nchecks = 0;
    int         nerr = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    truth_table_scanner_if #(.N_IN(N_IN)) bus0 ();
    truth_table_scanner_if #(.N_IN(N_IN)) bus1 ();

    truth_table_scanner #(.N_IN(N_IN), .SETTLE(SET0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    truth_table_scanner #(.N_IN(N_IN), .SETTLE(SET1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.start = start;
    assign bus0.abort = abort;
    assign bus0.s_in  = fn_tbl[bus0.vec];
    assign bus1.start = start;
    assign bus1.abort = abort;
    assign bus1.s_in  = fn_tbl[bus1.vec];

    // Reference: k counts edges since the accepting edge; row r lands at
    // k=(r+1)*(SETTLE+1), done at k=ROWS*(SETTLE+1)+1, abort effective before that.
    bit         m_act[2];
    int         m_k[2];
    logic [2:0] m_vec[2];
    logic       m_busy[2], m_done[2], m_abt[2], m_rv[2], m_bit[2];
    logic [2:0] m_idx[2];
    logic [7:0] m_tbl[2];
    logic [3:0] m_ones[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int per = ((i == 0) ? SET0 : SET1) + 1;
            automatic int kn  = m_k[i] + 1;
            automatic int r   = kn / per - 1;
            m_done[i] <= 1'b0;
            m_abt[i]  <= 1'b0;
            m_rv[i]   <= 1'b0;
            if (!rst_n) begin
                m_act[i]  <= 1'b0;
                m_k[i]    <= 0;
                m_vec[i]  <= 3'd0;
                m_busy[i] <= 1'b0;
                m_idx[i]  <= 3'd0;
                m_bit[i]  <= 1'b0;
                m_tbl[i]  <= 8'h00;
                m_ones[i] <= 4'd0;
            end else if (!m_act[i]) begin
                if (start) begin
                    m_act[i]  <= 1'b1;
                    m_k[i]    <= 0;
                    m_busy[i] <= 1'b1;
                    m_vec[i]  <= 3'd0;
                    m_tbl[i]  <= 8'h00;
                    m_ones[i] <= 4'd0;
                end
            end else begin
                m_k[i] <= kn;
                if (abort && kn <= ROWS * per) begin
                    m_act[i]  <= 1'b0;
                    m_busy[i] <= 1'b0;
                    m_abt[i]  <= 1'b1;
                end else if (kn == ROWS * per + 1) begin
                    m_act[i]  <= 1'b0;
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                end else if (kn % per == 0) begin
                    m_tbl[i]  <= m_tbl[i] | (8'(fn_tbl[r]) << r);
                    m_ones[i] <= m_ones[i] + 4'(fn_tbl[r]);
                    m_rv[i]   <= 1'b1;
                    m_idx[i]  <= 3'(r);
                    m_bit[i]  <= fn_tbl[r];
                    if (r < ROWS - 1) m_vec[i] <= 3'(r + 1);
                end
            end
        end
    end

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input int i, input logic [2:0] vec, input logic busy, input logic done,
                            input logic abt, input logic rv, input logic [2:0] idx, input logic bt,
                            input logic [7:0] tb, input logic [3:0] ones);
        check("vec", i, 32'(vec), 32'(m_vec[i]));
        check("busy", i, 32'(busy), 32'(m_busy[i]));
        check("done", i, 32'(done), 32'(m_done[i]));
        check("aborted", i, 32'(abt), 32'(m_abt[i]));
        check("row_valid", i, 32'(rv), 32'(m_rv[i]));
        check("tbl", i, 32'(tb), 32'(m_tbl[i]));
        check("ones_cnt", i, 32'(ones), 32'(m_ones[i]));
        if (m_rv[i]) begin
            check("row_idx", i, 32'(idx), 32'(m_idx[i]));
            check("row_bit", i, 32'(bt), 32'(m_bit[i]));
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, bus0.vec, bus0.busy, bus0.done, bus0.aborted, bus0.row_valid,
                     bus0.row_idx, bus0.row_bit, bus0.tbl, bus0.ones_cnt);
            cmp_inst(1, bus1.vec, bus1.busy, bus1.done, bus1.aborted, bus1.row_valid,
                     bus1.row_idx, bus1.row_bit, bus1.tbl, bus1.ones_cnt);
        end
    end

    int          w_done_at[2], w_done_cnt[2];
    int          w_rv_cnt, w_abt_cnt;
    bit          w_idx_ok;
    logic [63:0] w_busy0;

    // Observe n cycles after the accepting edge; sample k is taken after edge k.
    task automatic watch(input int n);
        w_done_at  = '{-1, -1};
        w_done_cnt = '{0, 0};
        w_rv_cnt   = 0;
        w_abt_cnt  = 0;
        w_idx_ok   = 1'b1;
        w_busy0    = 64'd0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (bus0.done) begin
                w_done_cnt[0]++;
                if (w_done_at[0] < 0) w_done_at[0] = k;
            end
            if (bus1.done) begin
                w_done_cnt[1]++;
                if (w_done_at[1] < 0) w_done_at[1] = k;
            end
            if (bus0.row_valid) begin
                if (bus0.row_idx != 3'(w_rv_cnt)) w_idx_ok = 1'b0;
                w_rv_cnt++;
            end
            if (bus0.aborted) w_abt_cnt++;
            if (k < 64) w_busy0[k] = bus0.busy;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        fn_tbl = 8'h30;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 0, 32'(bus0.busy), 32'd0);
        check("rst_tbl", 0, 32'(bus0.tbl), 32'd0);
        check("rst_vec", 0, 32'(bus0.vec), 32'd0);
        check("rst_ones", 0, 32'(bus0.ones_cnt), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // x & ~y with default settle
        pulse_start();
        watch(20);
        check("t1_done_at", 0, 32'(w_done_at[0]), 32'd17);
        check("t1_done_cnt", 0, 32'(w_done_cnt[0]), 32'd1);
        check("t1_rv_cnt", 0, 32'(w_rv_cnt), 32'd8);
        check("t1_idx_seq", 0, 32'(w_idx_ok), 32'd1);
        check("t1_tbl", 0, 32'(bus0.tbl), 32'h30);
        check("t1_ones", 0, 32'(bus0.ones_cnt), 32'd2);
        idle(20);

        // s tied high, SETTLE=3 instance
        fn_tbl = 8'hFF;
        pulse_start();
        watch(36);
        check("t2_done_at", 1, 32'(w_done_at[1]), 32'd33);
        check("t2_tbl", 1, 32'(bus1.tbl), 32'hFF);
        check("t2_ones", 1, 32'(bus1.ones_cnt), 32'd8);
        check("t2_done_at", 0, 32'(w_done_at[0]), 32'd17);
        idle(4);

        // abort in the SAMPLE cycle of row 3
        fn_tbl = 8'h30;
        pulse_start();
        idle(7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_aborted", 0, 32'(bus0.aborted), 32'd1);
        check("t3_busy", 0, 32'(bus0.busy), 32'd0);
        check("t3_rv", 0, 32'(bus0.row_valid), 32'd0);
        check("t3_tbl", 0, 32'(bus0.tbl), 32'd0);
        check("t3_ones", 0, 32'(bus0.ones_cnt), 32'd0);
        watch(20);
        check("t3_no_done", 0, 32'(w_done_cnt[0]), 32'd0);
        check("t3_no_rows", 0, 32'(w_rv_cnt), 32'd0);
        idle(4);

        // start held across the whole scan
        fn_tbl = 8'hA5;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        watch(18);
        start = 1'b0;
        check("t4_done_cnt", 0, 32'(w_done_cnt[0]), 32'd1);
        check("t4_done_at", 0, 32'(w_done_at[0]), 32'd17);
        check("t4_busy_k16", 0, 32'(w_busy0[16]), 32'd1);
        check("t4_busy_k17", 0, 32'(w_busy0[17]), 32'd0);
        check("t4_busy_k18", 0, 32'(w_busy0[18]), 32'd1);
        idle(40);

        // reset mid-scan at row 5 (row 4 already captured as 1)
        fn_tbl = 8'h30;
        pulse_start();
        idle(11);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_tbl", 0, 32'(bus0.tbl), 32'd0);
        check("t5_ones", 0, 32'(bus0.ones_cnt), 32'd0);
        check("t5_busy", 0, 32'(bus0.busy), 32'd0);
        check("t5_vec", 0, 32'(bus0.vec), 32'd0);
        check("t5_pulses", 0, 32'({bus0.done, bus0.aborted, bus0.row_valid, bus0.row_bit, bus0.row_idx}), 32'd0);
        rst_n = 1'b1;
        pulse_start();
        watch(20);
        check("t5_done_at", 0, 32'(w_done_at[0]), 32'd17);
        check("t5_tbl_full", 0, 32'(bus0.tbl), 32'h30);
        idle(20);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t6_busy", 0, 32'(bus0.busy), 32'd1);
        check("t6_aborted", 0, 32'(bus0.aborted), 32'd0);
        watch(20);
        check("t6_done_at", 0, 32'(w_done_at[0]), 32'd17);
        check("t6_no_abort", 0, 32'(w_abt_cnt), 32'd0);
        check("t6_tbl", 0, 32'(bus0.tbl), 32'h30);
        idle(20);

        // randomized traffic including function changes mid-scan
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 29) == 0);
            rst_n = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 15) == 0) fn_tbl = 8'($urandom);
        end
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        idle(40);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
